// File: rtl/second_order_sigdel_multichannel.sv
// Time-multiplexed second-order sigma-delta modulator.
// One shared datapath walks NUM_CHANNELS channels round-robin. Per-channel
// integrators, feedback bit and input sample sit in register arrays.
// Runtime first/second-order select, saturating integrators and sticky
// per-channel overload flags.
module second_order_sigdel_multichannel #(
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_WIDTH   = 2,
    parameter int INPUT_WIDTH  = 24,
    parameter int ACC_WIDTH    = 28
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    in_valid,
    input  logic [CHAN_WIDTH-1:0]   in_channel,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [CHAN_WIDTH-1:0]   out_channel,
    output logic                    out_bit,
    output logic [NUM_CHANNELS-1:0] overload,
    input  logic                    overload_clr
);

    // Two guard bits above the integrator width so sums never wrap before clamping.
    localparam int SUM_WIDTH = ACC_WIDTH + 2;

    localparam logic signed [SUM_WIDTH-1:0] FS =
        {{(SUM_WIDTH-INPUT_WIDTH){1'b0}}, 1'b1, {(INPUT_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_WIDTH-1:0] ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] ACC_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CHAN_WIDTH-1:0]       LAST_SLOT = CHAN_WIDTH'(NUM_CHANNELS - 1);

    logic [CHAN_WIDTH-1:0]         slot;
    logic [INPUT_WIDTH-1:0]        sample [NUM_CHANNELS];
    logic signed [ACC_WIDTH-1:0]   int1   [NUM_CHANNELS];
    logic signed [ACC_WIDTH-1:0]   int2   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]       last_bit;

    logic [INPUT_WIDTH-1:0]        cur_sample;
    logic signed [ACC_WIDTH-1:0]   cur_int1;
    logic signed [ACC_WIDTH-1:0]   cur_int2;
    logic signed [SUM_WIDTH-1:0]   x_ext;
    logic signed [SUM_WIDTH-1:0]   fb;
    logic signed [SUM_WIDTH-1:0]   int1_ext;
    logic signed [SUM_WIDTH-1:0]   int2_ext;
    logic signed [SUM_WIDTH-1:0]   int1_new_ext;
    logic signed [SUM_WIDTH-1:0]   sum1;
    logic signed [SUM_WIDTH-1:0]   sum2;
    logic signed [ACC_WIDTH-1:0]   int1_new;
    logic signed [ACC_WIDTH-1:0]   int2_new;
    logic                          clamp1;
    logic                          clamp2;
    logic                          bit_new;
    logic [NUM_CHANNELS-1:0]       ov_set;

    // Shared modulator datapath for the channel in the current slot.
    always_comb begin
        cur_sample = sample[slot];
        cur_int1   = int1[slot];
        cur_int2   = int2[slot];

        x_ext    = {{(SUM_WIDTH-INPUT_WIDTH){cur_sample[INPUT_WIDTH-1]}}, cur_sample};
        int1_ext = {{2{cur_int1[ACC_WIDTH-1]}}, cur_int1};
        int2_ext = {{2{cur_int2[ACC_WIDTH-1]}}, cur_int2};
        fb       = last_bit[slot] ? FS : -FS;

        sum1     = int1_ext + x_ext - fb;
        clamp1   = 1'b0;
        int1_new = sum1[ACC_WIDTH-1:0];
        if (sum1 > ACC_MAX) begin
            int1_new = ACC_MAX[ACC_WIDTH-1:0];
            clamp1   = 1'b1;
        end else if (sum1 < ACC_MIN) begin
            int1_new = ACC_MIN[ACC_WIDTH-1:0];
            clamp1   = 1'b1;
        end

        int1_new_ext = {{2{int1_new[ACC_WIDTH-1]}}, int1_new};
        sum2         = int2_ext + int1_new_ext - fb;
        clamp2       = 1'b0;
        int2_new     = '0;
        if (mode) begin
            bit_new = ~int1_new[ACC_WIDTH-1];
        end else begin
            int2_new = sum2[ACC_WIDTH-1:0];
            if (sum2 > ACC_MAX) begin
                int2_new = ACC_MAX[ACC_WIDTH-1:0];
                clamp2   = 1'b1;
            end else if (sum2 < ACC_MIN) begin
                int2_new = ACC_MIN[ACC_WIDTH-1:0];
                clamp2   = 1'b1;
            end
            bit_new = ~int2_new[ACC_WIDTH-1];
        end

        ov_set = '0;
        if (enable && (clamp1 || clamp2)) begin
            ov_set[slot] = 1'b1;
        end
    end

    // Sample capture; out-of-range channel writes are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample <= '{default: '0};
        end else if (in_valid && (32'(in_channel) < 32'(NUM_CHANNELS))) begin
            sample[in_channel] <= in_data;
        end
    end

    // Slot advance and per-channel state write-back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot     <= '0;
            int1     <= '{default: '0};
            int2     <= '{default: '0};
            last_bit <= '0;
        end else if (enable) begin
            int1[slot]     <= int1_new;
            int2[slot]     <= int2_new;
            last_bit[slot] <= bit_new;
            slot           <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
        end
    end

    // Registered bitstream output; channel/bit hold while disabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_bit     <= 1'b0;
        end else begin
            out_valid <= enable;
            if (enable) begin
                out_channel <= slot;
                out_bit     <= bit_new;
            end
        end
    end

    // Sticky overload flags; a new clamp outranks a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overload <= '0;
        end else begin
            overload <= (overload & {NUM_CHANNELS{~overload_clr}}) | ov_set;
        end
    end

    // Ready is low only while held in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_second_order_sigdel_multichannel.sv
// Directed bench for second_order_sigdel_multichannel: a default 4-channel
// instance and a 3-channel, 26-bit instance for overload and range checks.
module tb_second_order_sigdel_multichannel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, mode, in_valid, in_ready, out_valid, out_bit, overload_clr;
    logic [1:0]  in_channel, out_channel;
    logic [23:0] in_data;
    logic [3:0]  overload;

    logic        ov_rst_n, ov_en, ov_mode, ov_in_valid, ov_in_ready, ov_out_valid, ov_out_bit, ov_clr;
    logic [1:0]  ov_in_channel, ov_out_channel;
    logic [23:0] ov_in_data;
    logic [2:0]  ov_overload;

    second_order_sigdel_multichannel #(
        .NUM_CHANNELS(4), .CHAN_WIDTH(2), .INPUT_WIDTH(24), .ACC_WIDTH(28)
    ) u_dut (
        .clock(clk), .reset(rst_n), .enable(en), .mode(mode),
        .in_valid(in_valid), .in_channel(in_channel), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_channel(out_channel),
        .out_bit(out_bit), .overload(overload), .overload_clr(overload_clr)
    );

    second_order_sigdel_multichannel #(
        .NUM_CHANNELS(3), .CHAN_WIDTH(2), .INPUT_WIDTH(24), .ACC_WIDTH(26)
    ) u_ov (
        .clock(clk), .reset(ov_rst_n), .enable(ov_en), .mode(ov_mode),
        .in_valid(ov_in_valid), .in_channel(ov_in_channel), .in_data(ov_in_data),
        .in_ready(ov_in_ready), .out_valid(ov_out_valid), .out_channel(ov_out_channel),
        .out_bit(ov_out_bit), .overload(ov_overload), .overload_clr(ov_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ones [4];

    // Hand-derived per-visit bit patterns from a cleared state.
    bit pat_so  [7] = '{1, 1, 0, 1, 0, 0, 1};  // second order, zero input
    bit pat_fo  [6] = '{1, 1, 0, 1, 0, 1};     // first order, zero input
    bit pat_ch2 [4] = '{1, 1, 0, 0};           // first order, -FS written during visit 2
    bit pat_ov0 [7] = '{1, 0, 0, 0, 0, 0, 0};  // second order, -FS input

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic write_main(input logic [1:0] ch, input logic [23:0] d);
        in_valid = 1'b1; in_channel = ch; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic write_ov(input logic [1:0] ch, input logic [23:0] d);
        ov_in_valid = 1'b1; ov_in_channel = ch; ov_in_data = d;
        tick();
        ov_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        in_channel = '0; in_data = '0; overload_clr = 1'b0;
        ov_rst_n = 1'b0; ov_en = 1'b0; ov_mode = 1'b0; ov_in_valid = 1'b0;
        ov_in_channel = '0; ov_in_data = '0; ov_clr = 1'b0;

        // Reset values
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_channel", out_channel, 0);
        check("rst_overload", overload, 0);
        check("rst_in_ready", in_ready, 0);
        tick();
        check("rst_in_ready_edge", in_ready, 0);
        check("rst_out_valid_edge", out_valid, 0);
        rst_n = 1'b1;

        // Second order, zero input: channel rotation and 1,1,0,1 per channel
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("so_valid_k%0d", k), out_valid, 1);
            check($sformatf("so_chan_k%0d", k), out_channel, k % 4);
            check($sformatf("so_bit_k%0d", k), out_bit, pat_so[k / 4]);
        end
        check("so_in_ready", in_ready, 1);
        check("so_overload", overload, 0);

        // First order, zero input: 1,1,0,1,0,1
        mode = 1'b1;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            tick();
            check($sformatf("fo_chan_k%0d", k), out_channel, k % 4);
            check($sformatf("fo_bit_k%0d", k), out_bit, pat_fo[k / 4]);
        end

        // DC inputs: ones density over 1024 visits per channel
        mode = 1'b0; en = 1'b0;
        do_reset();
        write_main(2'd0, 24'h200000);
        write_main(2'd1, 24'hE00000);
        write_main(2'd2, 24'h000000);
        write_main(2'd3, 24'h3FFFFF);
        for (int c = 0; c < 4; c++) ones[c] = 0;
        en = 1'b1;
        for (int k = 0; k < 4096; k++) begin
            tick();
            if (out_valid) ones[out_channel] += int'(out_bit);
        end
        check_range("dc_ones_ch0", ones[0], 636, 644);
        check_range("dc_ones_ch1", ones[1], 380, 388);
        check_range("dc_ones_ch2", ones[2], 508, 516);
        check_range("dc_ones_ch3", ones[3], 764, 772);
        check("dc_overload", overload, 0);

        // Write to ch2 while ch2 is processed: old sample now, new one next visit
        mode = 1'b1;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("wr_chan_k%0d", k), out_channel, k % 4);
            check($sformatf("wr_bit_k%0d", k), out_bit,
                  (k % 4 == 2) ? pat_ch2[k / 4] : pat_fo[k / 4]);
            if (k == 5) begin
                in_valid = 1'b1; in_channel = 2'd2; in_data = 24'h800000;
            end
            if (k == 6) in_valid = 1'b0;
        end

        // Enable gap of 7 cycles: outputs hold, slot resumes, stream unchanged
        mode = 1'b0;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            tick();
            check($sformatf("gap_pre_chan_k%0d", k), out_channel, k % 4);
            check($sformatf("gap_pre_bit_k%0d", k), out_bit, pat_so[k / 4]);
        end
        en = 1'b0;
        for (int g = 0; g < 7; g++) begin
            tick();
            check($sformatf("gap_valid_g%0d", g), out_valid, 0);
            check($sformatf("gap_hold_chan_g%0d", g), out_channel, 1);
            check($sformatf("gap_hold_bit_g%0d", g), out_bit, 1);
        end
        en = 1'b1;
        for (int k = 14; k < 28; k++) begin
            tick();
            check($sformatf("gap_post_valid_k%0d", k), out_valid, 1);
            check($sformatf("gap_post_chan_k%0d", k), out_channel, k % 4);
            check($sformatf("gap_post_bit_k%0d", k), out_bit, pat_so[k / 4]);
        end

        // Async reset between edges clears outputs immediately
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_bit", out_bit, 0);
        check("arst_out_channel", out_channel, 0);
        check("arst_overload", overload, 0);
        check("arst_in_ready", in_ready, 0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("arst_post_valid_k%0d", k), out_valid, 1);
            check($sformatf("arst_post_chan_k%0d", k), out_channel, k);
            check($sformatf("arst_post_bit_k%0d", k), out_bit, 1);
        end

        // 3-channel, 26-bit instance: overload, clear, set-wins, out-of-range write
        ov_rst_n = 1'b1;
        write_ov(2'd0, 24'h800000);
        write_ov(2'd3, 24'h7FFFFF);
        check("ov_in_ready", ov_in_ready, 1);
        check("ov_idle_valid", ov_out_valid, 0);
        ov_en = 1'b1;
        for (int k = 0; k < 19; k++) begin
            tick();
            check($sformatf("ov_chan_k%0d", k), ov_out_channel, k % 3);
            check($sformatf("ov_bit_k%0d", k), ov_out_bit,
                  (k % 3 == 0) ? pat_ov0[k / 3] : pat_so[k / 3]);
            check($sformatf("ov_flag_k%0d", k), ov_overload,
                  ((k >= 12 && k <= 15) || k >= 18) ? 3'b001 : 3'b000);
            if (k == 14) ov_clr = 1'b1;
            if (k == 16) ov_clr = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/second_order_sigdel_multichannel.md
Name: second_order_sigdel_multichannel

Overview:
Time-multiplexed second-order sigma-delta modulator. One shared datapath serves NUM_CHANNELS independent channels in round-robin slots. Per-channel integrator state and input samples live in register arrays. The block adds a runtime first/second-order mode, integrator saturation and per-channel sticky overload flags. It sits between the sample-distribution logic and the per-channel bitstream output pins/filters.

Parameters:
NUM_CHANNELS, 4, number of virtual modulator channels (2..16)
CHAN_WIDTH, 2, width of channel index; must satisfy 2^CHAN_WIDTH >= NUM_CHANNELS
INPUT_WIDTH, 24, signed two's-complement input sample width
ACC_WIDTH, 28, signed integrator width; must be >= INPUT_WIDTH+2

Ports:
clock  in  1  modulator clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = advance slot and update state each cycle
mode  in  1  0 = second order, 1 = first order
in_valid  in  1  write strobe for in_data/in_channel
in_channel  in  CHAN_WIDTH  target channel of write
in_data  in  INPUT_WIDTH  signed sample
in_ready  out  1  always 1 after reset release; 0 while reset low
out_valid  out  1  out_bit/out_channel valid this cycle
out_channel  out  CHAN_WIDTH  channel of out_bit
out_bit  out  1  modulator output bit
overload  out  NUM_CHANNELS  sticky per-channel integrator saturation flag
overload_clr  in  1  clears all overload bits

Behaviour:
- Reset (reset=0, async): slot=0; all int1, int2, last_bit, sample registers = 0; out_valid=0, out_bit=0, out_channel=0, overload=0, in_ready=0.
- Input: when in_valid=1 and in_channel<NUM_CHANNELS, sample[in_channel] <= in_data at the edge. Out-of-range channel writes are ignored. No backpressure.
- Slot counter: counts 0..NUM_CHANNELS-1 and wraps to 0 when enable=1. It holds when enable=0.
- Each enabled cycle for channel s = slot:
  - x = sign-extend(sample[s]) to ACC_WIDTH.
  - FS = 2^(INPUT_WIDTH-1).
  - fb = last_bit[s] ? +FS : -FS.
  - int1' = sat(int1[s] + x - fb).
  - Second order: int2' = sat(int2[s] + int1' - fb), and bit = (int2' >= 0).
  - First order: int2' = 0, and bit = (int1' >= 0).
  - Write back int1, int2 and last_bit for channel s.
- Timing: the computation uses the sample register value before the edge. A write to channel s in the same cycle that s is processed takes effect on s's next visit.
- Output latency is 1 cycle, registered. In the cycle after processing slot s: out_valid=1, out_channel=s, out_bit=bit. When enable=0, out_valid=0 and out_bit/out_channel hold.
- Saturation: sat() clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp on int1' or int2' sets overload[s].
- Overload clear: overload_clr=1 clears all bits. If a set and a clear hit the same channel in the same cycle, set wins.
- Mode change takes effect on the next processed slot. No state flush; int2 becomes 0 on each channel's first first-order visit.
- Reset mid-operation: all state is cleared immediately, regardless of slot.

Test Plan:
- Reset, then release with NUM_CHANNELS=4, enable=1 → out_valid rises 1 cycle after release, and out_channel sequence is 0,1,2,3,0,1.
- All samples=0, mode=0 → each channel's first four bits are 1,1,0,1. With mode=1 they are 1,1,0,1,0,1.
- ch0=+2^21, ch1=-2^21, ch2=0, ch3=+2^22-1, 1024 visits each, mode=0 → ones counts 640±4, 384±4, 512±4, 768±4. overload stays 0.
- ACC_WIDTH=26, ch0=-2^23 (full negative), mode=0 → overload[0]=1 within 16 visits and other bits stay 0. overload_clr pulse → 0. The flag re-asserts while the stimulus persists.
- in_valid to ch2 in the same cycle slot=2 → that visit uses the old sample and the next visit uses the new one. in_channel=5 with NUM_CHANNELS=4 → no state change.
- enable low for 7 cycles mid-stream → out_valid=0, and the slot resumes where it stopped. The bitstream is identical to the uninterrupted run. Async reset asserted mid-slot → all outputs go to 0 within the same cycle.
